// File: rtl/multicycle_data_path_if.sv
// Memory/bus port of the multicycle datapath.
// One shared instruction/data port with a valid/ready handshake.
//   mem_req   : request valid (master -> slave)
//   mem_we    : request is a write
//   mem_addr  : byte address of the request
//   mem_wdata : store data
//   mem_rdata : read data, valid together with mem_ready
//   mem_ready : request accepted/completed this cycle
interface multicycle_data_path_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_data_path.sv
// Multicycle ARM-subset datapath: phase FSM, 16-entry register file, ALU,
// one shared memory port with valid/ready handshake and a bus timeout.
// Control comes from an external decoder looking at `instruction`.
//
// Ports:
//   clk, rst          : clock (rising edge), async active-low reset
//   instruction       : instruction register (IR) to the decoder
//   cond_ok .. alu_control : decoder control inputs
//   alu_flags         : registered NZCV
//   pc, state         : program counter, current phase
//   mem               : memory port (master side)
//   bus_error         : sticky timeout flag
//   instr_done        : one-cycle pulse per retired/annulled instruction
//
// State table:
//   state     | meaning
//   FETCH     | read instruction at pc, pc += 4
//   DECODE    | latch A, B, IMM; annul on condition fail
//   EXECUTE   | ALU; branches retire here
//   MEMORY    | load/store access at ALUOut
//   WRITEBACK | write ALUOut or MDR to Rd (Rd=15 goes to pc)
//   HALT      | bus timeout; only reset leaves
module multicycle_data_path #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [WIDTH-1:0]      instruction,
    input  logic                  cond_ok,
    input  logic                  reg_write,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  alu_src,
    input  logic                  branch,
    input  logic [1:0]            imm_src,
    input  logic [1:0]            reg_src,
    input  logic [3:0]            alu_control,
    output logic [3:0]            alu_flags,
    output logic [WIDTH-1:0]      pc,
    output logic [2:0]            state,
    multicycle_data_path_if.master mem,
    output logic                  bus_error,
    output logic                  instr_done
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam int unsigned TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, ir_q, a_q, b_q, imm_q, alu_out_q, mdr_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] regs [16];
    logic [TW-1:0]    wait_q;
    logic             bus_error_q, done_q;

    logic [23:0]      ir24;
    logic [3:0]       rn, rm, rd;
    logic [WIDTH-1:0] pc_plus4, rn_val, rm_val, rd_val, imm_d, alu_b, y, wb_val;
    logic [WIDTH:0]   sum;
    logic             c_out, v_out;
    logic [3:0]       flags_y;
    logic             bus_wait, timeout_hit;

    // Field extraction through a fixed 24-bit view keeps narrow WIDTHs legal.
    assign ir24     = 24'(ir_q);
    assign rn       = reg_src[0] ? 4'd15 : ir24[19:16];
    assign rm       = reg_src[1] ? ir24[15:12] : ir24[3:0];
    assign rd       = ir24[15:12];
    assign pc_plus4 = pc_q + WIDTH'(4);

    // pc already points past the current instruction, so R15 reads fetch+8.
    assign rn_val = (rn == 4'd15) ? pc_plus4 : regs[rn];
    assign rm_val = (rm == 4'd15) ? pc_plus4 : regs[rm];
    assign rd_val = (rd == 4'd15) ? pc_plus4 : regs[rd];

    always_comb begin
        imm_d = '0;
        case (imm_src)
            2'b00:   imm_d = WIDTH'(ir24[7:0]);
            2'b01:   imm_d = WIDTH'(ir24[11:0]);
            2'b10:   imm_d = WIDTH'($signed({ir24, 2'b00}));
            default: imm_d = '0;
        endcase
    end

    assign alu_b = alu_src ? imm_q : b_q;

    always_comb begin
        sum   = '0;
        y     = '0;
        c_out = 1'b0;
        v_out = 1'b0;
        case (alu_control)
            4'h0: begin
                sum   = {1'b0, a_q} + {1'b0, alu_b};
                y     = sum[WIDTH-1:0];
                c_out = sum[WIDTH];
                v_out = (a_q[WIDTH-1] == alu_b[WIDTH-1]) && (y[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'h1: begin
                // A + ~B + 1: carry out is NOT borrow
                sum   = {1'b0, a_q} + {1'b0, ~alu_b} + (WIDTH + 1)'(1);
                y     = sum[WIDTH-1:0];
                c_out = sum[WIDTH];
                v_out = (a_q[WIDTH-1] != alu_b[WIDTH-1]) && (y[WIDTH-1] != a_q[WIDTH-1]);
            end
            4'h2:    y = a_q & alu_b;
            4'h3:    y = a_q | alu_b;
            4'h4:    y = a_q ^ alu_b;
            4'h5:    y = alu_b;
            4'h6:    y = ~alu_b;
            default: y = '0;
        endcase
    end

    assign flags_y = {y[WIDTH-1], (y == '0), c_out, v_out};
    assign wb_val  = mem_to_reg ? mdr_q : alu_out_q;

    // Bus outputs follow the phase; reset forces the port idle immediately.
    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (rst) begin
            if (state_q == S_FETCH) begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = pc_q;
            end else if (state_q == S_MEMORY) begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = mem_write;
                mem.mem_addr  = alu_out_q;
                mem.mem_wdata = rd_val;
            end
        end
    end

    assign bus_wait    = mem.mem_req && !mem.mem_ready;
    assign timeout_hit = TO_EN && bus_wait && (wait_q == TW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem.mem_ready)    state_d = S_DECODE;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_DECODE:  state_d = cond_ok ? S_EXECUTE : S_FETCH;
            S_EXECUTE: begin
                if (branch)                       state_d = S_FETCH;
                else if (mem_write || mem_to_reg) state_d = S_MEMORY;
                else                              state_d = S_WRITEBACK;
            end
            S_MEMORY: begin
                if (mem.mem_ready)    state_d = mem_write ? S_FETCH : S_WRITEBACK;
                else if (timeout_hit) state_d = S_HALT;
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            alu_out_q   <= '0;
            mdr_q       <= '0;
            flags_q     <= '0;
            wait_q      <= TW'(TIMEOUT);
            bus_error_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            done_q <= 1'b0;
            // Down-counter of remaining wait cycles; reloaded whenever the bus is not stalled.
            if (TO_EN && bus_wait) wait_q <= wait_q - TW'(1);
            else                   wait_q <= TW'(TIMEOUT);

            case (state_q)
                S_FETCH: begin
                    if (mem.mem_ready) begin
                        ir_q <= mem.mem_rdata;
                        pc_q <= pc_plus4;
                    end else if (timeout_hit) begin
                        bus_error_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    a_q   <= rn_val;
                    b_q   <= rm_val;
                    imm_q <= imm_d;
                    if (!cond_ok) done_q <= 1'b1;
                end
                S_EXECUTE: begin
                    alu_out_q <= y;
                    if (!branch && !mem_write && !mem_to_reg) flags_q <= flags_y;
                    if (branch) begin
                        pc_q   <= y;
                        done_q <= 1'b1;
                    end
                end
                S_MEMORY: begin
                    if (mem.mem_ready) begin
                        if (mem_write) done_q <= 1'b1;
                        else           mdr_q  <= mem.mem_rdata;
                    end else if (timeout_hit) begin
                        bus_error_q <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    done_q <= 1'b1;
                    if (reg_write) begin
                        if (rd == 4'd15) pc_q     <= wb_val;
                        else             regs[rd] <= wb_val;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instruction = ir_q;
    assign alu_flags   = flags_q;
    assign pc          = pc_q;
    assign state       = state_q;
    assign bus_error   = bus_error_q;
    assign instr_done  = done_q;

endmodule

// File: doc/multicycle_data_path.md
Name: multicycle_data_path

Overview:
- Parametrised multicycle successor to the single-cycle ARM-subset datapath.
- One unified memory port with a valid/ready handshake, an internal phase FSM, an internal register file, an ALU and a bus timeout.
- Sits between the existing decoder/controller, which drives combinational control from `instruction`, and a shared instruction/data memory or bus that may stall.

Parameters:
- WIDTH, 32: datapath, register and address width (≥16).
- RESET_PC, 0: value loaded into PC on reset.
- TIMEOUT, 15: max wait cycles for mem_ready before bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instruction  out  WIDTH  instruction register (IR), to decoder.
- cond_ok  in  1  condition passed (decoder, from IR and alu_flags).
- reg_write  in  1  write Rd in WRITEBACK.
- mem_write  in  1  instruction is a store.
- mem_to_reg  in  1  instruction is a load.
- alu_src  in  1  ALU B = immediate (1) / register (0).
- branch  in  1  instruction is a branch.
- imm_src  in  2  immediate format.
- reg_src  in  2  register-address selects.
- alu_control  in  4  ALU operation.
- alu_flags  out  4  registered NZCV.
- pc  out  WIDTH  program counter.
- state  out  3  current FSM state.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- mem_addr  out  WIDTH  request address.
- mem_wdata  out  WIDTH  store data.
- mem_rdata  in  WIDTH  read data, valid with mem_ready.
- mem_ready  in  1  request accepted/completed this cycle.
- bus_error  out  1  sticky timeout flag.
- instr_done  out  1  one-cycle pulse per retired instruction.

Behaviour:
- **Reset (rst=0, async):**
  - pc=RESET_PC; IR=0; alu_flags=0; state=FETCH; bus_error=0; all mem_* outputs 0; instr_done=0.
  - All 16 registers are cleared to 0.
  - Reset mid-transaction abandons the request immediately; there is no replay.
- **State encoding:** FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- **FETCH:**
  - Drive mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
  - Otherwise hold all outputs stable.
- **DECODE:**
  - Rn = reg_src[0] ? 15 : IR[19:16]; Rm = reg_src[1] ? IR[15:12] : IR[3:0].
  - Latch A<=R[Rn], B<=R[Rm]. Reading R15 returns pc+4, i.e. the fetch address + 8.
  - Extend IR into IMM:
    - imm_src=00: zero-extend IR[7:0].
    - imm_src=01: zero-extend IR[11:0].
    - imm_src=10: sign-extend IR[23:0]<<2.
    - imm_src=11: 0.
  - If cond_ok=0: pulse instr_done, go to FETCH (instruction is annulled).
  - Otherwise go to EXECUTE.
- **EXECUTE:**
  - Y = A op (alu_src ? IMM : B); latch ALUOut<=Y.
  - Operations: 0000 ADD, 0001 SUB (A−B), 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (pass B), 0110 MVN (~B), others give Y=0.
  - Flags: N=Y[WIDTH-1], Z=(Y==0). C is the carry-out for ADD and NOT borrow for SUB. V is signed overflow for ADD/SUB. C and V are 0 for logic ops.
  - alu_flags updates only on data-processing instructions (not branch, not load/store).
  - If branch: pc<=Y, pulse instr_done, go to FETCH.
  - Else if mem_write or mem_to_reg: go to MEMORY.
  - Else go to WRITEBACK.
- **MEMORY:**
  - mem_req=1, mem_addr=ALUOut, mem_we=mem_write, mem_wdata=R[IR[15:12]].
  - On mem_ready:
    - Store: pulse instr_done, go to FETCH.
    - Load: MDR<=mem_rdata, go to WRITEBACK.
- **WRITEBACK:**
  - Result = mem_to_reg ? MDR : ALUOut.
  - If reg_write: R[IR[15:12]]<=result. If Rd==15, pc<=result instead; the register-array entry is not written.
  - Pulse instr_done, go to FETCH.
- **Timeout:**
  - A wait counter clears on entry to FETCH/MEMORY and counts cycles with mem_req=1 and mem_ready=0.
  - When the counter reaches TIMEOUT: bus_error<=1, go to HALT.
- **HALT:** all mem_* outputs are 0. Only reset exits HALT.
- **Handshake:** mem_addr/mem_we/mem_wdata are stable while mem_req=1 and until mem_ready. mem_req drops in the cycle after acceptance.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH; pc wraps silently.
- **Latency:** with zero-wait memory:
  - Data-processing: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Annulled instruction: 2 cycles.

Test Plan:
- **Reset/fetch:** RESET_PC=0x100, release rst, mem_ready=1 with rdata=ADD-immediate R1=R0+5 → mem_addr=0x100 in FETCH; R1=5 after 4 cycles; pc=0x104; instr_done one pulse.
- **Flags:** R0=0x7FFFFFFF, ADD imm 1 → R1=0x80000000, alu_flags=1001. Then SUB R2=R1−R1 → Z=1, C=1.
- **Load/store with wait states:** mem_ready delayed 3 cycles. STR R1,[R0,#4] then LDR R3 → mem_addr/wdata held stable across the waits; R3 equals the stored value; load takes 8 cycles.
- **Branch and R15:** branch imm24=2 at 0x100 → pc=0x110. Writeback of 0x200 to Rd=15 → next fetch at 0x200.
- **Condition fail:** cond_ok=0 in DECODE → no register/flag change, back to FETCH after 2 cycles, pc advanced by 4.
- **Timeout:** TIMEOUT=15, mem_ready held 0 → bus_error=1 and state=HALT after 15 wait cycles, mem_req=0. Async rst mid-HALT → outputs return to reset values.
